// File: rtl/poly_coeff_accumulator.sv
// poly_coeff_accumulator: accumulates tagged partial-product terms into an N-entry
// coefficient bank with negacyclic reduction (x^N = -1, coefficients mod 2^W), then
// streams the N result coefficients out over a valid/ready interface.
module poly_coeff_accumulator #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 8,
    parameter int unsigned IW = 3,
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          prod_valid,
    input  logic [IW-1:0] prod_idx,
    input  logic [W-1:0]  prod_data,
    input  logic          prod_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_idx,
    output logic          busy,
    output logic          done,
    output logic          idx_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int unsigned MAX_IDX = 2 * N - 2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [W-1:0]  bank     [N];
    logic [W-1:0]  bank_nxt [N];
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] rd_ptr_inc;
    logic [CW-1:0] wr_idx;
    logic          wr_sub;
    logic          term_en;
    logic          term_err;
    logic          hs;
    logic          last_hs;
    logic          enter_drain;

    // Next-state and per-cycle control decode; start outranks everything else.
    always_comb begin
        state_nxt   = state;
        term_en     = 1'b0;
        term_err    = 1'b0;
        wr_idx      = '0;
        wr_sub      = 1'b0;
        hs          = 1'b0;
        last_hs     = 1'b0;
        enter_drain = 1'b0;
        rd_ptr_inc  = rd_ptr + CW'(1);
        case (state)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            ST_ACCUM: begin
                if (prod_valid && !start) begin
                    if (prod_idx < IW'(N)) begin
                        term_en = 1'b1;
                        wr_idx  = CW'(prod_idx);
                    end else if (prod_idx <= IW'(MAX_IDX)) begin
                        term_en = 1'b1;
                        wr_sub  = 1'b1;
                        wr_idx  = CW'(prod_idx - IW'(N));
                    end else begin
                        term_err = 1'b1;
                    end
                    if (prod_last) begin
                        state_nxt   = ST_DRAIN;
                        enter_drain = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                hs      = out_valid && out_ready && !start;
                last_hs = hs && (rd_ptr == CW'(N - 1));
                if (last_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (start) begin
            state_nxt = ACCUM_STATE();
        end
    end

    function automatic logic [1:0] ACCUM_STATE();
        return ST_ACCUM;
    endfunction

    // Bank after this cycle's term; x^N wraps to -1 so upper exponents subtract.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            bank_nxt[i] = bank[i];
        end
        if (term_en) begin
            if (wr_sub) begin
                bank_nxt[wr_idx] = bank[wr_idx] - prod_data;
            end else begin
                bank_nxt[wr_idx] = bank[wr_idx] + prod_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Coefficient bank: cleared by start, otherwise takes the accumulated value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N); i++) begin
                bank[i] <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < int'(N); i++) begin
                bank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                bank[i] <= bank_nxt[i];
            end
        end
    end

    // Output stream, read pointer and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
            idx_err   <= 1'b0;
        end else begin
            done <= last_hs;
            if (start) begin
                rd_ptr    <= '0;
                out_valid <= 1'b0;
                out_idx   <= '0;
                idx_err   <= 1'b0;
            end else begin
                if (term_err) begin
                    idx_err <= 1'b1;
                end
                if (enter_drain) begin
                    // Forward the final term so coefficient 0 is correct on the first beat.
                    out_valid <= 1'b1;
                    out_data  <= bank_nxt[0];
                    out_idx   <= '0;
                    rd_ptr    <= '0;
                end else if (last_hs) begin
                    out_valid <= 1'b0;
                    out_idx   <= '0;
                    rd_ptr    <= '0;
                end else if (hs) begin
                    rd_ptr   <= rd_ptr_inc;
                    out_idx  <= rd_ptr_inc;
                    out_data <= bank[rd_ptr_inc];
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_poly_coeff_accumulator.sv
// tb_poly_coeff_accumulator: scoreboard bench; a reference negacyclic model queues the
// expected coefficients when the last term is sent, a negedge monitor pops and compares.
module tb_poly_coeff_accumulator;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          prod_valid;
    logic [IW-1:0] prod_idx;
    logic [W-1:0]  prod_data;
    logic          prod_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_idx;
    logic          busy;
    logic          done;
    logic          idx_err;

    int n_tests;
    int n_fail;

    logic [W-1:0] mbank [N];
    logic         merr;
    int           q_data[$];
    int           q_idx[$];
    logic         exp_done;

    poly_coeff_accumulator #(.N(N), .W(W), .IW(IW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prod_valid (prod_valid),
        .prod_idx   (prod_idx),
        .prod_data  (prod_data),
        .prod_last  (prod_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .busy       (busy),
        .done       (done),
        .idx_err    (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(N); i++) mbank[i] = '0;
        merr = 1'b0;
        q_data.delete();
        q_idx.delete();
    endtask

    task automatic do_start(input bit with_term);
        start = 1'b1;
        if (with_term) begin
            prod_valid = 1'b1;
            prod_idx   = IW'(0);
            prod_data  = W'(99);
            prod_last  = 1'b0;
        end
        cyc();
        start      = 1'b0;
        prod_valid = 1'b0;
        model_clear();
        check("start_busy", 32'(busy), 32'd1);
        check("start_idx_err", 32'(idx_err), 32'd0);
        check("start_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic send(input int k, input int d, input bit last);
        prod_valid = 1'b1;
        prod_idx   = IW'(k);
        prod_data  = W'(d);
        prod_last  = last;
        cyc();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        if (k < int'(N)) mbank[k] = mbank[k] + W'(d);
        else if (k <= int'(2 * N - 2)) mbank[k - int'(N)] = mbank[k - int'(N)] - W'(d);
        else merr = 1'b1;
        if (last) begin
            for (int i = 0; i < int'(N); i++) begin
                q_data.push_back(int'(mbank[i]));
                q_idx.push_back(i);
            end
        end
    endtask

    // Drain with ready either held high or toggling 1,0,0,1,0,0...
    task automatic drain(input bit toggle, output int cycles);
        cycles = 0;
        while (q_data.size() > 0 && cycles < 64) begin
            out_ready = toggle ? ((cycles % 3) == 0) : 1'b1;
            cyc();
            cycles++;
        end
        out_ready = 1'b0;
        check("drain_left", 32'(q_data.size()), 32'd0);
        check("drain_done", 32'(done), 32'd1);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    // Output monitor: every valid beat must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (reset) begin
            exp_done = 1'b0;
        end else begin
            check("done_pulse", 32'(done), 32'(exp_done));
            exp_done = 1'b0;
            if (out_valid) begin
                if (q_data.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    check("out_data", 32'(out_data), 32'(q_data[0]));
                    check("out_idx", 32'(out_idx), 32'(q_idx[0]));
                    if (out_ready) begin
                        if (q_idx[0] == int'(N - 1)) exp_done = 1'b1;
                        void'(q_data.pop_front());
                        void'(q_idx.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        n_tests    = 0;
        n_fail     = 0;
        exp_done   = 1'b0;
        reset      = 1'b1;
        start      = 1'b0;
        prod_valid = 1'b0;
        prod_idx   = '0;
        prod_data  = '0;
        prod_last  = 1'b0;
        out_ready  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx_err", 32'(idx_err), 32'd0);
        reset = 1'b0;
        cyc();

        // Basic accumulation, ready held high: N-cycle drain.
        do_start(1'b0);
        send(0, 1, 1'b0);
        send(1, 1, 1'b0);
        send(1, 1, 1'b0);
        send(2, 1, 1'b1);
        check("lat_valid", 32'(out_valid), 32'd1);
        drain(1'b0, ncyc);
        check("drain_cycles", 32'(ncyc), 32'(N));

        // Negacyclic wrap.
        do_start(1'b0);
        send(4, 3, 1'b0);
        send(0, 1, 1'b0);
        send(6, 2, 1'b1);
        drain(1'b0, ncyc);

        // Modular overflow.
        do_start(1'b0);
        send(0, 200, 1'b0);
        send(0, 100, 1'b1);
        drain(1'b0, ncyc);

        // Backpressure: toggling ready must hold data/idx without loss or duplicate.
        do_start(1'b0);
        send(0, 10, 1'b0);
        send(1, 20, 1'b0);
        send(2, 30, 1'b0);
        send(3, 40, 1'b0);
        send(5, 7, 1'b1);
        drain(1'b1, ncyc);

        // Terms outside ACCUM are ignored and never flag an error.
        prod_valid = 1'b1;
        prod_idx   = IW'(7);
        prod_data  = W'(50);
        cyc();
        prod_idx = IW'(0);
        cyc();
        prod_valid = 1'b0;
        check("idle_idx_err", 32'(idx_err), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Out-of-range last term: flags error, still drains an empty bank.
        do_start(1'b0);
        send(7, 5, 1'b1);
        check("oor_idx_err", 32'(idx_err), 32'(merr));
        check("oor_valid", 32'(out_valid), 32'd1);
        drain(1'b0, ncyc);

        // Asynchronous reset in ACCUM.
        do_start(1'b0);
        send(0, 5, 1'b0);
        send(7, 1, 1'b0);
        check("pre_rst_idx_err", 32'(idx_err), 32'd1);
        prod_valid = 1'b1;
        prod_idx   = IW'(1);
        prod_data  = W'(3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_idx_err", 32'(idx_err), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        model_clear();
        prod_valid = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();

        // Restart mid-DRAIN with a colliding term that must be dropped.
        do_start(1'b0);
        send(1, 9, 1'b0);
        send(7, 1, 1'b0);
        send(2, 4, 1'b1);
        check("mid_idx_err", 32'(idx_err), 32'd1);
        out_ready = 1'b1;
        cyc();
        cyc();
        out_ready = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        do_start(1'b1);
        send(3, 6, 1'b1);
        drain(1'b0, ncyc);

        cyc();
        check("final_queue", 32'(q_data.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
